// File: rtl/div_share_arbiter_if.sv
// Request, divider and response bundle for div_share_arbiter.
//   req0_*/req1_* : two valid/ready requesters carrying dividend x and divisor y
//   div_*         : launch pulse, captured operands and result/done from the divider
//   rsp_*         : shared valid/ready response (id, quotient, remainder, error)
//   busy          : arbiter is not idle
// slave is the arbiter's view; master is the surrounding environment's view.
interface div_share_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_x;
  logic [WIDTH-1:0] req0_y;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_x;
  logic [WIDTH-1:0] req1_y;
  logic             div_start;
  logic [WIDTH-1:0] div_x;
  logic [WIDTH-1:0] div_y;
  logic             div_done;
  logic [WIDTH-1:0] div_quot;
  logic [WIDTH:0]   div_rem;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_quot;
  logic [WIDTH:0]   rsp_rem;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    output req0_ready, req1_ready,
    output div_start, div_x, div_y,
    input  div_done, div_quot, div_rem,
    output rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, busy,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    input  req0_ready, req1_ready,
    input  div_start, div_x, div_y,
    output div_done, div_quot, div_rem,
    input  rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err, busy,
    output rsp_ready
  );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin sharing of one multi-cycle divider between two requesters.
// Captures operands on the request handshake, launches the divider, waits for
// done under a watchdog, and returns the result on a shared response channel.
// Divide-by-zero is answered locally without starting the divider.
// Ports:
//   clk   : rising-edge clock
//   rst_b : asynchronous active-low reset
//   bus   : div_share_arbiter_if.slave (requests, divider, response, busy)
module div_share_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 100
) (
  input logic                  clk,
  input logic                  rst_b,
  div_share_arbiter_if.slave   bus
);

  localparam int unsigned WD_W    = 8;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic             cur_id_q, cur_id_d;
  logic [WIDTH-1:0] div_x_q, div_x_d;
  logic [WIDTH-1:0] div_y_q, div_y_d;
  logic [WIDTH-1:0] rsp_quot_q, rsp_quot_d;
  logic [WIDTH:0]   rsp_rem_q, rsp_rem_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             div_start_q;
  logic             rsp_valid_q;
  logic             busy_q;

  logic             sel;
  logic             idle;
  logic             accept;
  logic [WIDTH-1:0] acc_x;
  logic [WIDTH-1:0] acc_y;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    sel = ~last_id_q;
    if (bus.req0_valid && !bus.req1_valid) begin
      sel = 1'b0;
    end else if (!bus.req0_valid && bus.req1_valid) begin
      sel = 1'b1;
    end
  end

  assign idle           = (state_q == S_IDLE);
  assign bus.req0_ready = idle && bus.req0_valid && !sel;
  assign bus.req1_ready = idle && bus.req1_valid && sel;
  assign accept         = bus.req0_ready || bus.req1_ready;
  assign acc_x          = sel ? bus.req1_x : bus.req0_x;
  assign acc_y          = sel ? bus.req1_y : bus.req0_y;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    last_id_d  = last_id_q;
    cur_id_d   = cur_id_q;
    div_x_d    = div_x_q;
    div_y_d    = div_y_q;
    rsp_quot_d = rsp_quot_q;
    rsp_rem_d  = rsp_rem_q;
    rsp_err_d  = rsp_err_q;
    wdog_d     = wdog_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          div_x_d   = acc_x;
          div_y_d   = acc_y;
          cur_id_d  = sel;
          last_id_d = sel;
          if (acc_y == '0) begin
            rsp_err_d  = 1'b1;
            rsp_quot_d = '1;
            rsp_rem_d  = {1'b0, acc_x};
            state_d    = S_RESP;
          end else begin
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the timeout cycle still delivers the real result.
        if (bus.div_done) begin
          rsp_quot_d = bus.div_quot;
          rsp_rem_d  = bus.div_rem;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else if (wdog_q == WD_LAST) begin
          rsp_quot_d = '0;
          rsp_rem_d  = '0;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs; strobes are decoded from the next state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      last_id_q   <= 1'b1;
      cur_id_q    <= 1'b0;
      div_x_q     <= '0;
      div_y_q     <= '0;
      rsp_quot_q  <= '0;
      rsp_rem_q   <= '0;
      rsp_err_q   <= 1'b0;
      wdog_q      <= '0;
      div_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_id_q   <= last_id_d;
      cur_id_q    <= cur_id_d;
      div_x_q     <= div_x_d;
      div_y_q     <= div_y_d;
      rsp_quot_q  <= rsp_quot_d;
      rsp_rem_q   <= rsp_rem_d;
      rsp_err_q   <= rsp_err_d;
      wdog_q      <= wdog_d;
      div_start_q <= (state_d == S_LAUNCH);
      rsp_valid_q <= (state_d == S_RESP);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign bus.div_start = div_start_q;
  assign bus.div_x     = div_x_q;
  assign bus.div_y     = div_y_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = cur_id_q;
  assign bus.rsp_quot  = rsp_quot_q;
  assign bus.rsp_rem   = rsp_rem_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule
